// File: rtl/lsu_pkg.sv
// Shared types and FUNCT3 encodings for the load/store unit.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_CAPTURE,
        S_MERGE,
        S_WRITE,
        S_RESP
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // Access size in bytes; the low two FUNCT3 bits encode log2(size) for loads and stores alike.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/load_store_unit_load_extract.sv
// Combinational load lane select and sign/zero extension.
// Zero latency; no flow control.
module load_extract
    import lsu_pkg::*;
(
    input  logic [63:0] data_i,
    input  logic [2:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [63:0] data_o
);

    logic [63:0] lane;

    assign lane = data_i >> {off_i, 3'b000};

    always_comb begin
        data_o = lane;
        case (funct3_i)
            F3_LB:   data_o = {{56{lane[7]}},  lane[7:0]};
            F3_LH:   data_o = {{48{lane[15]}}, lane[15:0]};
            F3_LW:   data_o = {{32{lane[31]}}, lane[31:0]};
            F3_LBU:  data_o = {56'd0, lane[7:0]};
            F3_LHU:  data_o = {48'd0, lane[15:0]};
            F3_LWU:  data_o = {32'd0, lane[31:0]};
            default: data_o = lane;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV64 data-memory access stage: loads with extension, sub-doubleword stores by read-modify-write.
// Latency: load LAT+2, partial store LAT+3, sd 2, fault 1 cycle(s); START ignored while BUSY.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_RD_LAT = 1,
    parameter int ADDR_W     = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              is_store_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [63:0]       store_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fault_o,
    output logic [63:0]       load_data_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [63:0]       mem_datain_o,
    input  logic [63:0]       mem_dataout_i,
    output logic              mem_wr_o
);

    localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic              is_store_q;
    logic [63:0]       store_q;
    logic              fault_q;
    logic [63:0]       load_data_q;
    logic [63:0]       wdata_q;

    logic [3:0]        req_size;
    logic              req_illegal;
    logic              req_misal;
    logic              req_fault;
    logic              req_sd;
    logic              accept;
    logic [63:0]       ext_data;
    logic [63:0]       lane_mask;
    logic [63:0]       merged;

    // Request decode is done on the live inputs because the IDLE branch must already pick the next state.
    assign req_size    = size_bytes(funct3_i);
    assign req_illegal = is_store_i ? funct3_i[2] : (funct3_i == 3'b111);
    assign req_misal   = (addr_i[2:0] & (req_size[2:0] - 3'd1)) != 3'd0;
    assign req_fault   = req_illegal | req_misal;
    assign req_sd      = is_store_i & (funct3_i == F3_SD);
    assign accept      = (state_q == S_IDLE) & start_i;

    load_extract u_load_extract (
        .data_i   (mem_dataout_i),
        .off_i    (addr_q[2:0]),
        .funct3_i (funct3_q),
        .data_o   (ext_data)
    );

    always_comb begin
        lane_mask = '1;
        case (funct3_q[1:0])
            2'd0:    lane_mask = 64'h0000_0000_0000_00FF;
            2'd1:    lane_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = '1;
        endcase
        lane_mask = lane_mask << {addr_q[2:0], 3'b000};
        merged    = (mem_dataout_i & ~lane_mask)
                  | ((store_q << {addr_q[2:0], 3'b000}) & lane_mask);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (req_fault) begin
                        state_d = S_RESP;
                    end else if (req_sd) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RD_WAIT;
                        cnt_d   = CNT_W'(MEM_RD_LAT - 1);
                    end
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = is_store_q ? S_MERGE : S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_CAPTURE: state_d = S_RESP;
            S_MERGE:   state_d = S_WRITE;
            S_WRITE:   state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            funct3_q    <= '0;
            is_store_q  <= 1'b0;
            store_q     <= '0;
            fault_q     <= 1'b0;
            load_data_q <= '0;
            wdata_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q     <= addr_i;
                funct3_q   <= funct3_i;
                is_store_q <= is_store_i;
                store_q    <= store_data_i;
                fault_q    <= req_fault;
                if (req_sd && !req_fault) begin
                    wdata_q <= store_data_i;
                end
            end
            if (state_q == S_CAPTURE) begin
                load_data_q <= ext_data;
            end
            if (state_q == S_MERGE) begin
                wdata_q <= merged;
            end
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_RESP);
    assign fault_o      = (state_q == S_RESP) & fault_q;
    assign mem_wr_o     = (state_q == S_WRITE);
    assign load_data_o  = load_data_q;
    assign mem_raddr_o  = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_waddr_o  = {addr_q[ADDR_W-1:3], 3'b000};
    assign mem_datain_o = wdata_q;

endmodule
